// File: rtl/dtree_pkg.sv
// dtree_pkg: FSM states, the fixed two-node oblique tree and sizing helpers shared by the
// dtree classifier and its node MAC.
package dtree_pkg;

    typedef enum logic [1:0] {StCollect, StEvalRoot, StEvalChild} state_e;

    localparam int unsigned NodeCount = 2;
    localparam int unsigned NodeW = $clog2(NodeCount);
    typedef logic [NodeW-1:0] node_t;

    localparam node_t RootNode  = node_t'(0);
    localparam node_t ChildNode = node_t'(1);

    // Coefficients beyond TreeFeatures read as zero, so longer vectors still work.
    localparam int unsigned TreeFeatures = 3;
    localparam int NodeCoeff [NodeCount][TreeFeatures] = '{'{1, 0, 0}, '{0, 1, -1}};
    localparam int NodeThresh [NodeCount] = '{512, 0};

    // Leaf flag per node and branch, indexed [node][decision]; decision 1 = right.
    localparam bit NodeLeaf [NodeCount][2] = '{'{1'b1, 1'b0}, '{1'b1, 1'b1}};

    function automatic int node_coeff(input node_t n, input int unsigned i);
        int c;
        c = 0;
        for (int unsigned k = 0; k < TreeFeatures; k++) begin
            if (k == i) c = NodeCoeff[n][k];
        end
        return c;
    endfunction

    function automatic int node_thresh(input node_t n);
        return NodeThresh[n];
    endfunction

    function automatic int unsigned acc_width(input int unsigned in_w, input int unsigned coeff_w,
                                              input int unsigned features);
        return in_w + coeff_w + unsigned'($clog2(features)) + 1;
    endfunction

endpackage

// File: rtl/dtree_node_mac.sv
// dtree_node_mac: signed dot product of one tree node's coefficients with the feature vector.
// Default is one term per cycle; DTREE_PARALLEL_MAC_EN sums all terms combinationally.
module dtree_node_mac
    import dtree_pkg::*;
#(
    parameter int unsigned FEATURES    = 3,
    parameter int unsigned IN_WIDTH    = 10,
    parameter int unsigned COEFF_WIDTH = 4,
    parameter int unsigned ACC_WIDTH   = acc_width(IN_WIDTH, COEFF_WIDTH, FEATURES)
) (
`ifndef DTREE_PARALLEL_MAC_EN
    input  logic                              clk,
    input  logic                              reset,
`endif
    input  logic [FEATURES-1:0][IN_WIDTH-1:0] feat,
    input  node_t                             node,
    input  logic                              start,
    output logic signed [ACC_WIDTH-1:0]       acc,
    output logic                              done
);

    // Coefficient is sign-extended, sample zero-extended, before the multiply.
    function automatic logic signed [ACC_WIDTH-1:0] mac_term(input node_t n,
                                                             input logic [IN_WIDTH-1:0] x,
                                                             input int unsigned i);
        logic signed [COEFF_WIDTH-1:0] c;
        logic signed [ACC_WIDTH-1:0]   c_ext;
        logic signed [ACC_WIDTH-1:0]   x_ext;
        c     = COEFF_WIDTH'(node_coeff(n, i));
        c_ext = ACC_WIDTH'(c);
        x_ext = ACC_WIDTH'(x);
        return c_ext * x_ext;
    endfunction

`ifndef DTREE_PARALLEL_MAC_EN
    localparam int unsigned IdxW = $clog2(FEATURES);
    localparam logic [IdxW-1:0] LastIdx = IdxW'(FEATURES - 1);

    logic [IdxW-1:0]             idx_q;
    logic                        busy_q;
    logic signed [ACC_WIDTH-1:0] acc_q;
    logic                        run;

    always_comb begin
        run  = start | busy_q;
        acc  = acc_q + mac_term(node, feat[idx_q], 32'(idx_q));
        done = run && (idx_q == LastIdx);
    end

    // acc_q is cleared on the final term so the next node starts from zero.
    always_ff @(posedge clk) begin
        if (reset) begin
            idx_q  <= '0;
            busy_q <= 1'b0;
            acc_q  <= '0;
        end else if (run) begin
            idx_q  <= done ? '0 : idx_q + 1'b1;
            busy_q <= !done;
            acc_q  <= done ? '0 : acc;
        end
    end
`else
    always_comb begin
        acc = '0;
        for (int unsigned i = 0; i < FEATURES; i++) begin
            acc = acc + mac_term(node, feat[i], i);
        end
        done = start;
    end
`endif

endmodule

// File: rtl/dtree.sv
// dtree: oblique two-level decision-tree classifier over a valid/ready sample stream.
// Define DTREE_PARALLEL_MAC_EN for single-cycle node evaluation.
module dtree
    import dtree_pkg::*;
#(
    parameter int unsigned FEATURES    = 3,
    parameter int unsigned IN_WIDTH    = 10,
    parameter int unsigned COEFF_WIDTH = 4
) (
    input  logic                clk,
    input  logic                reset,
    output logic                ready,
    input  logic                in_valid,
    input  logic [IN_WIDTH-1:0] sample,
    output logic [1:0]          level,
    output logic [1:0]          path,
    output logic                out_valid
);

    localparam int unsigned ACC_WIDTH = acc_width(IN_WIDTH, COEFF_WIDTH, FEATURES);
    localparam int unsigned IdxW = $clog2(FEATURES);
    localparam logic [IdxW-1:0] LastIdx = IdxW'(FEATURES - 1);

    state_e                            state_q, state_d;
    logic [IdxW-1:0]                   idx_q, idx_d;
    logic [FEATURES-1:0][IN_WIDTH-1:0] feat_q, feat_d;
    logic                              d0_q, d0_d;
    logic                              start_q, start_d;
    logic [1:0]                        level_q, level_d;
    logic [1:0]                        path_q, path_d;
    logic                              out_valid_q, out_valid_d;

    node_t                       node_sel;
    logic signed [ACC_WIDTH-1:0] acc;
    logic signed [ACC_WIDTH-1:0] thresh;
    logic                        mac_done;
    logic                        decision;

    dtree_node_mac #(
        .FEATURES    (FEATURES),
        .IN_WIDTH    (IN_WIDTH),
        .COEFF_WIDTH (COEFF_WIDTH),
        .ACC_WIDTH   (ACC_WIDTH)
    ) u_mac (
`ifndef DTREE_PARALLEL_MAC_EN
        .clk   (clk),
        .reset (reset),
`endif
        .feat  (feat_q),
        .node  (node_sel),
        .start (start_q),
        .acc   (acc),
        .done  (mac_done)
    );

    always_comb begin
        node_sel = (state_q == StEvalChild) ? ChildNode : RootNode;
        thresh   = ACC_WIDTH'(node_thresh(node_sel));
        decision = (acc >= thresh);
    end

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        feat_d      = feat_q;
        d0_d        = d0_q;
        start_d     = 1'b0;
        level_d     = level_q;
        path_d      = path_q;
        out_valid_d = 1'b0;

        unique case (state_q)
            StCollect: begin
                if (in_valid) begin
                    feat_d[idx_q] = sample;
                    if (idx_q == LastIdx) begin
                        idx_d   = '0;
                        state_d = StEvalRoot;
                        start_d = 1'b1;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
            StEvalRoot: begin
                if (mac_done) begin
                    d0_d = decision;
                    if (NodeLeaf[RootNode][decision]) begin
                        level_d     = 2'd1;
                        path_d      = {1'b0, decision};
                        out_valid_d = 1'b1;
                        state_d     = StCollect;
                    end else begin
                        start_d = 1'b1;
                        state_d = StEvalChild;
                    end
                end
            end
            StEvalChild: begin
                if (mac_done) begin
                    level_d     = 2'd2;
                    path_d      = {decision, d0_q};
                    out_valid_d = 1'b1;
                    state_d     = StCollect;
                end
            end
            default: state_d = StCollect;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= StCollect;
            idx_q       <= '0;
            feat_q      <= '0;
            d0_q        <= 1'b0;
            start_q     <= 1'b0;
            level_q     <= 2'd0;
            path_q      <= 2'd0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            feat_q      <= feat_d;
            d0_q        <= d0_d;
            start_q     <= start_d;
            level_q     <= level_d;
            path_q      <= path_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign ready     = (state_q == StCollect);
    assign level     = level_q;
    assign path      = path_q;
    assign out_valid = out_valid_q;

endmodule

// File: tb/tb_dtree.sv
// tb_dtree: randomized and directed stimulus for dtree, checked every cycle against a
// transaction-level model of the tree (depth, branch bits and result latency).
module tb_dtree;

    localparam int F = 3;
`ifdef DTREE_PARALLEL_MAC_EN
    localparam int EvalCycles = 1;
`else
    localparam int EvalCycles = F;
`endif

    logic       clk = 1'b0;
    logic       reset;
    logic       ready;
    logic       in_valid;
    logic [9:0] sample;
    logic [1:0] level;
    logic [1:0] path;
    logic       out_valid;

    always #5 clk = ~clk;

    dtree dut (
        .clk       (clk),
        .reset     (reset),
        .ready     (ready),
        .in_valid  (in_valid),
        .sample    (sample),
        .level     (level),
        .path      (path),
        .out_valid (out_valid)
    );

    int errors = 0;
    int checks = 0;

    // Model state: samples gathered, remaining busy cycles, pending and visible result.
    int m_feat[F];
    int m_cnt = 0;
    int m_busy = 0;
    int m_ov = 0;
    int m_level = 0;
    int m_path = 0;
    int m_pend_level = 0;
    int m_pend_path = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0d, expected %0d", tag, $time, got, exp);
        end
    endtask

    // Root tests f0 >= 512; right child tests f1 - f2 >= 0.
    task automatic classify(output int lvl, output int pth);
        if (m_feat[0] >= 512) begin
            lvl = 2;
            pth = (m_feat[1] - m_feat[2] >= 0) ? 3 : 1;
        end else begin
            lvl = 1;
            pth = 0;
        end
    endtask

    task automatic model_edge(input bit v, input int s);
        int ov_n;
        int lvl;
        int pth;
        ov_n = 0;
        if (m_busy > 0) begin
            m_busy--;
            if (m_busy == 0) begin
                ov_n    = 1;
                m_level = m_pend_level;
                m_path  = m_pend_path;
            end
        end else if (v) begin
            m_feat[m_cnt] = s;
            m_cnt++;
            if (m_cnt == F) begin
                m_cnt = 0;
                classify(lvl, pth);
                m_pend_level = lvl;
                m_pend_path  = pth;
                m_busy       = EvalCycles * lvl;
            end
        end
        m_ov = ov_n;
    endtask

    // Called at a negedge: drive inputs, check outputs, advance one clock.
    task automatic cycle(input bit v, input logic [9:0] s);
        in_valid = v;
        sample   = s;
        check("ready", 32'(ready), 32'(m_busy == 0));
        check("out_valid", 32'(out_valid), 32'(m_ov));
        check("level", 32'(level), 32'(m_level));
        check("path", 32'(path), 32'(m_path));
        @(posedge clk);
        model_edge(v, int'(s));
        @(negedge clk);
    endtask

    task automatic do_reset();
        reset    = 1'b1;
        in_valid = 1'($urandom);
        sample   = 10'($urandom);
        @(posedge clk);
        m_cnt   = 0;
        m_busy  = 0;
        m_ov    = 0;
        m_level = 0;
        m_path  = 0;
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) cycle(1'b0, 10'($urandom));
    endtask

    task automatic send_vec(input int a, input int b, input int c);
        cycle(1'b1, 10'(a));
        cycle(1'b1, 10'(b));
        cycle(1'b1, 10'(c));
    endtask

    initial begin
        reset    = 1'b1;
        in_valid = 1'b0;
        sample   = '0;
        @(negedge clk);
        do_reset();
        idle(2);

        send_vec(100, 200, 300); idle(2 * F + 2);
        send_vec(600, 300, 200); idle(2 * F + 2);
        send_vec(600, 100, 200); idle(2 * F + 2);
        send_vec(512, 5, 5);     idle(2 * F + 2);
        send_vec(511, 900, 0);   idle(2 * F + 2);
        send_vec(1023, 0, 1023); idle(2 * F + 2);

        // Reset mid-vector, then a clean vector.
        cycle(1'b1, 10'd700);
        cycle(1'b1, 10'd50);
        do_reset();
        send_vec(100, 200, 300); idle(2 * F + 2);

        // Reset mid-evaluation must suppress the result.
        send_vec(600, 300, 200);
        idle(2);
        do_reset();
        idle(2 * F + 2);

        // Continuous traffic: offers while busy are ignored.
        repeat (80) cycle(1'b1, 10'($urandom));

        repeat (500) begin
            logic [9:0] s;
            if ($urandom_range(0, 199) == 0) begin
                do_reset();
            end else begin
                case ($urandom_range(0, 5))
                    0:       s = 10'd512;
                    1:       s = 10'd511;
                    default: s = 10'($urandom);
                endcase
                cycle($urandom_range(0, 3) != 0, s);
            end
        end
        idle(2 * F + 2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
